// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the sequential ALU and its multiplier.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mul_unit.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
// done is high during the last iteration; product is valid in that same cycle.
module seq_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic               running;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign done     = running && (cnt == CW'(WIDTH - 1));
    // Exposing the final accumulation lets the consumer capture on the done edge.
    assign product  = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            cnt <= cnt + CW'(1);
            if (done) running <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/seq_alu_n.sv
// Registered ALU with valid/ready on both sides; MUL iterates in seq_mul_unit.
// Optional Z/OV flag outputs are enabled by defining ALU_FLAGS_EN.
module seq_alu_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             CI,
    input  logic [2:0]       A,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Cout,
    output logic             CO,
    output logic             busy
`ifdef ALU_FLAGS_EN
    ,
    output logic             Z,
    output logic             OV
`endif
);
    localparam int SHW = $clog2(WIDTH);

    state_t             state;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     shr;
    logic [WIDTH-1:0]   res;
    logic               res_co;
    logic               res_ov;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (A == OP_MUL);
    assign shamt     = In2[SHW-1:0];

    seq_mul_unit #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (In1),
        .b       (In2),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Extra bit on the shift operands catches the last bit shifted out (0 for amount 0).
    always_comb begin
        sum    = {1'b0, In1} + {1'b0, In2} + {{WIDTH{1'b0}}, CI};
        diff   = {1'b0, In1} - {1'b0, In2} - {{WIDTH{1'b0}}, CI};
        shl    = {1'b0, In1} << shamt;
        shr    = {In1, 1'b0} >> shamt;
        res    = '0;
        res_co = 1'b0;
        res_ov = 1'b0;
        case (A)
            OP_ADD: begin
                res    = sum[WIDTH-1:0];
                res_co = sum[WIDTH];
                res_ov = (In1[WIDTH-1] == In2[WIDTH-1]) && (sum[WIDTH-1] != In1[WIDTH-1]);
            end
            OP_SUB: begin
                res    = diff[WIDTH-1:0];
                res_co = diff[WIDTH];
                res_ov = (In1[WIDTH-1] != In2[WIDTH-1]) && (diff[WIDTH-1] != In1[WIDTH-1]);
            end
            OP_AND: res = In1 & In2;
            OP_OR:  res = In1 | In2;
            OP_XOR: res = In1 ^ In2;
            OP_SLL: begin
                res    = shl[WIDTH-1:0];
                res_co = shl[WIDTH];
            end
            OP_SRL: begin
                res    = shr[WIDTH:1];
                res_co = shr[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            Cout      <= '0;
            CO        <= 1'b0;
            busy      <= 1'b0;
`ifdef ALU_FLAGS_EN
            Z         <= 1'b0;
            OV        <= 1'b0;
`endif
        end else if (accept) begin
            if (A == OP_MUL) begin
                state     <= CALC;
                out_valid <= 1'b0;
                busy      <= 1'b1;
            end else begin
                state     <= DONE;
                out_valid <= 1'b1;
                Cout      <= res;
                CO        <= res_co;
`ifdef ALU_FLAGS_EN
                Z         <= (res == '0);
                OV        <= res_ov;
`endif
            end
        end else begin
            case (state)
                CALC: if (mul_done) begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    Cout      <= mul_prod[WIDTH-1:0];
                    CO        <= |mul_prod[2*WIDTH-1:WIDTH];
`ifdef ALU_FLAGS_EN
                    Z         <= (mul_prod[WIDTH-1:0] == '0);
                    OV        <= 1'b0;
`endif
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifndef ALU_FLAGS_EN
    logic unused_ov;
    assign unused_ov = res_ov;
`endif

endmodule
